fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage, directly upstream of the instruction decoder. Holds the PC, issues
//  req/ack reads to instruction memory, buffers returned words in a small FIFO and presents
//  one instruction + its PC per cycle to decode. Taken branches from execute flush and redirect.
// PARAMETERS
//  INST_W      16       instruction width (matches decoder input width)
//  PC_W        16       PC / instruction-memory word-address width
//  FIFO_DEPTH  2        prefetch buffer entries (power of two, >=2)
//  RESET_PC    16'h0000 first fetch address after reset
// PORTS
//  clk         in   1       system clock, all state on rising edge
//  rst         in   1       asynchronous, active-high reset
//  imem_req    out  1       read request to instruction memory
//  imem_addr   out  PC_W    word address of request (= fetch_pc)
//  imem_ack    in   1       same-cycle accept; imem_rdata valid for imem_addr this cycle
//  imem_rdata  in   INST_W  instruction word
//  br_taken    in   1       redirect pulse from execute
//  br_target   in   PC_W    redirect address
//  id_ready    in   1       decode stage can accept this cycle
//  id_valid    out  1       id_inst/id_pc hold a valid instruction
//  id_inst     out  INST_W  instruction to decoder
//  id_pc       out  PC_W    address of id_inst
// BEHAVIOUR
//  - Reset: state=BOOT, fetch_pc=RESET_PC, FIFO empty, imem_req=0, imem_addr=RESET_PC,
//    id_valid=0, id_inst=0, id_pc=0. Reset asserted mid-operation discards everything.
//  - FSM: BOOT -> RUN unconditionally (one cycle, req=0). RUN: req when FIFO count<FIFO_DEPTH.
//    br_taken in any state -> FLUSH. FLUSH: req=0 for one cycle -> RUN (br_taken in FLUSH
//    reloads target, stays FLUSH one more cycle).
//  - Handshake: imem_req/imem_addr driven combinationally from state; transfer when
//    imem_req&imem_ack. On transfer: push {fetch_pc, imem_rdata}, fetch_pc<=fetch_pc+1.
//    req held with stable addr until ack; no outstanding requests survive a cycle.
//  - fetch_pc arithmetic mod 2^PC_W: 16'hFFFF+1 -> 16'h0000, no flag.
//  - Output: id_valid = (count!=0); id_inst/id_pc = FIFO head. Pop when id_valid&id_ready.
//    Push and pop in same cycle allowed; count unchanged. Full: req=0, no push.
//    Empty: id_valid=0, id_inst/id_pc hold last value (don't-care).
//  - Redirect (br_taken=1): FIFO cleared, fetch_pc<=br_target, any same-cycle transfer
//    is dropped (fetch_pc not incremented); same-cycle pop is harmless. Priority:
//    rst > br_taken > push/pop.
//  - Latency: ack at edge t -> id_valid at t+1. br_taken at t -> req for br_target at t+2
//    -> earliest id_valid (target) at t+3.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds output perf_bubble_cnt [15:0], reset 0, increments each
//    cycle id_ready=1 && id_valid=0, saturates at 16'hFFFF, cleared only by rst.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1 rst, imem always ack, mem[i]=16'hA000+i, id_ready=1 -> id_pc 0,1,2.. with id_inst
//    A000,A001.. one per cycle; first id_valid 3 cycles after rst release (BOOT, req, push).
//  2 id_ready=0 for 10 cycles -> 2 entries then imem_req=0; id_ready=1 -> pc 0,1,2 in order,
//    no loss/duplication.
//  3 br_taken, br_target=16'h0040 while FIFO full -> next cycle id_valid=0, req=0;
//    then imem_addr=0040; first id_pc=0040.
//  4 br_taken same cycle as ack for addr 0005 -> 0005 word never reaches id_inst;
//    next fetch addr = br_target.
//  5 RESET_PC=16'hFFFE, run 4 fetches -> id_pc FFFE, FFFF, 0000, 0001.
//  6 imem_ack low 3 cycles -> imem_addr stable, req high; rst pulse mid-wait -> all outputs
//    reset values, fetch restarts at RESET_PC; with FETCH_PERF_CNT_EN, bubbles counted.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem req/ack, prefetch FIFO, branch redirect.
// Optional FETCH_PERF_CNT_EN adds the perf_bubble_cnt output.
module fetch_unit #(
  parameter int INST_W     = 16,
  parameter int PC_W       = 16,
  parameter int FIFO_DEPTH = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   br_target,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [INST_W-1:0] id_inst,
`ifdef FETCH_PERF_CNT_EN
  output logic [PC_W-1:0]   id_pc,
  output logic [15:0]       perf_bubble_cnt
`else
  output logic [PC_W-1:0]   id_pc
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_e;

  state_e            state_q;
  logic [PC_W-1:0]   fetch_pc_q;
  logic [INST_W-1:0] inst_q [FIFO_DEPTH];
  logic [PC_W-1:0]   pc_q   [FIFO_DEPTH];
  logic [AW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [AW:0]       count_q;
  logic              push, pop;

  assign imem_req  = (state_q == RUN) && (count_q < FULL_CNT);
  assign imem_addr = fetch_pc_q;
  assign push      = imem_req && imem_ack;
  assign id_valid  = (count_q != '0);
  assign pop       = id_valid && id_ready;
  assign id_inst   = inst_q[rd_ptr_q];
  assign id_pc     = pc_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (br_taken) begin
      // Redirect wins over any same-cycle transfer: the fetched word is dropped.
      state_q    <= FLUSH;
      fetch_pc_q <= br_target;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q <= RUN;
      if (push) begin
        inst_q[wr_ptr_q] <= imem_rdata;
        pc_q[wr_ptr_q]   <= fetch_pc_q;
        wr_ptr_q         <= wr_ptr_q + AW'(1);
        fetch_pc_q       <= fetch_pc_q + PC_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] bubble_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_q <= '0;
    end else if (id_ready && !id_valid && (bubble_q != 16'hFFFF)) begin
      bubble_q <= bubble_q + 16'd1;
    end
  end

  assign perf_bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack, br_taken, id_ready, id_valid;
  logic [15:0] imem_addr, imem_rdata, br_target, id_inst, id_pc;
  logic        imem_req2, id_valid2;
  logic [15:0] imem_addr2, imem_rdata2, id_inst2, id_pc2;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_bubble_cnt, perf_bubble_cnt2;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign imem_rdata  = 16'hA000 + imem_addr;
  assign imem_rdata2 = 16'hA000 + imem_addr2;

  fetch_unit #(.INST_W(16), .PC_W(16), .FIFO_DEPTH(2), .RESET_PC(16'h0000)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .br_taken(br_taken), .br_target(br_target),
    .id_ready(id_ready), .id_valid(id_valid), .id_inst(id_inst),
`ifdef FETCH_PERF_CNT_EN
    .id_pc(id_pc), .perf_bubble_cnt(perf_bubble_cnt)
`else
    .id_pc(id_pc)
`endif
  );

  fetch_unit #(.INST_W(16), .PC_W(16), .FIFO_DEPTH(2), .RESET_PC(16'hFFFE)) u_dut2 (
    .clk(clk), .rst(rst),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(1'b1), .imem_rdata(imem_rdata2),
    .br_taken(1'b0), .br_target(16'h0000),
    .id_ready(1'b1), .id_valid(id_valid2), .id_inst(id_inst2),
`ifdef FETCH_PERF_CNT_EN
    .id_pc(id_pc2), .perf_bubble_cnt(perf_bubble_cnt2)
`else
    .id_pc(id_pc2)
`endif
  );

  // Reference model of the main instance; sampled on the falling edge.
  logic [15:0] sb_q[$];
  logic [15:0] m_pc;
  logic [15:0] m_bub;
  int          m_state;
  logic        exp_req, exp_valid;

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      m_pc    = 16'h0000;
      m_state = 0;
      m_bub   = 16'h0000;
    end
    exp_req   = (m_state == 1) && (sb_q.size() < 2);
    exp_valid = (sb_q.size() != 0);
    n_cmp++;
    if (imem_req !== exp_req) begin
      n_fail++;
      $display("FAIL sb_req got=%b exp=%b t=%0t", imem_req, exp_req, $time);
    end
    if (exp_req) begin
      n_cmp++;
      if (imem_addr !== m_pc) begin
        n_fail++;
        $display("FAIL sb_addr got=%h exp=%h t=%0t", imem_addr, m_pc, $time);
      end
    end
    n_cmp++;
    if (id_valid !== exp_valid) begin
      n_fail++;
      $display("FAIL sb_valid got=%b exp=%b t=%0t", id_valid, exp_valid, $time);
    end
    if (exp_valid) begin
      n_cmp++;
      if (id_pc !== sb_q[0] || id_inst !== 16'(16'hA000 + sb_q[0])) begin
        n_fail++;
        $display("FAIL sb_head got=%h/%h exp=%h/%h t=%0t", id_pc, id_inst, sb_q[0],
                 16'(16'hA000 + sb_q[0]), $time);
      end
    end
`ifdef FETCH_PERF_CNT_EN
    n_cmp++;
    if (perf_bubble_cnt !== m_bub) begin
      n_fail++;
      $display("FAIL sb_bubble got=%0d exp=%0d", perf_bubble_cnt, m_bub);
    end
`endif
    if (!rst) begin
      if (id_ready && !exp_valid && m_bub != 16'hFFFF) m_bub = m_bub + 16'd1;
      if (br_taken) begin
        sb_q.delete();
        m_pc    = br_target;
        m_state = 2;
      end else begin
        if (exp_valid && id_ready) void'(sb_q.pop_front());
        if (exp_req && imem_ack) begin
          sb_q.push_back(m_pc);
          m_pc = m_pc + 16'd1;
        end
        m_state = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b1; id_ready = 1'b1; br_taken = 1'b0; br_target = 16'h0;
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b0 || imem_addr !== 16'h0000 || id_valid !== 1'b0 ||
        id_inst !== 16'h0000 || id_pc !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_vals got req=%b addr=%h v=%b inst=%h pc=%h exp 0/0000/0/0000/0000",
               imem_req, imem_addr, id_valid, id_inst, id_pc);
    end
    step();
    rst = 1'b0;
    step();
    n_cmp++;
    if (id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL boot_valid got=%b exp=0", id_valid);
    end
    step();
    n_cmp++;
    if (id_valid !== 1'b1 || id_pc !== 16'h0000 || id_inst !== 16'hA000) begin
      n_fail++;
      $display("FAIL first_out got v=%b pc=%h inst=%h exp 1/0000/A000", id_valid, id_pc, id_inst);
    end
    for (int i = 1; i < 6; i++) begin
      step();
      n_cmp++;
      if (id_valid !== 1'b1 || id_pc !== 16'(i)) begin
        n_fail++;
        $display("FAIL back_to_back got v=%b pc=%h exp 1/%h", id_valid, id_pc, 16'(i));
      end
    end
  endtask

  task automatic test_stall();
    id_ready = 1'b0;
    repeat (10) step();
    n_cmp++;
    if (imem_req !== 1'b0 || id_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_full got req=%b v=%b exp 0/1", imem_req, id_valid);
    end
    id_ready = 1'b1;
    repeat (6) step();
  endtask

  task automatic test_branch_full();
    bit seen = 0;
    id_ready = 1'b0;
    repeat (4) step();
    br_taken = 1'b1; br_target = 16'h0040;
    step();
    br_taken = 1'b0;
    n_cmp++;
    if (id_valid !== 1'b0 || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL br_flush got v=%b req=%b exp 0/0", id_valid, imem_req);
    end
    step();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin
      n_fail++;
      $display("FAIL br_req got req=%b addr=%h exp 1/0040", imem_req, imem_addr);
    end
    id_ready = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (id_valid) seen = 1;
    end
    n_cmp++;
    if (!seen || id_pc !== 16'h0040) begin
      n_fail++;
      $display("FAIL br_first got seen=%0d pc=%h exp 1/0040", seen, id_pc);
    end
  endtask

  task automatic test_branch_ack();
    bit found = 0;
    bit seen  = 0;
    br_taken = 1'b1; br_target = 16'h0003;
    step();
    br_taken = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (imem_req && imem_addr == 16'h0005) begin
        found = 1;
        br_taken = 1'b1; br_target = 16'h0100;
      end
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL br_ack_find got found=0 exp 1");
    end
    step();
    br_taken = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (id_valid) seen = 1;
    end
    n_cmp++;
    if (!seen || id_pc !== 16'h0100) begin
      n_fail++;
      $display("FAIL br_ack_first got seen=%0d pc=%h exp 1/0100", seen, id_pc);
    end
  endtask

  task automatic test_ack_wait_reset();
    logic [15:0] a0;
    bit seen = 0;
    imem_ack = 1'b0;
    step();
    a0 = imem_addr;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== a0) begin
        n_fail++;
        $display("FAIL ack_wait got req=%b addr=%h exp 1/%h", imem_req, imem_addr, a0);
      end
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (imem_req !== 1'b0 || imem_addr !== 16'h0000 || id_valid !== 1'b0 ||
        id_inst !== 16'h0000 || id_pc !== 16'h0000) begin
      n_fail++;
      $display("FAIL mid_reset got req=%b addr=%h v=%b inst=%h pc=%h exp 0/0000/0/0000/0000",
               imem_req, imem_addr, id_valid, id_inst, id_pc);
    end
    step();
    rst = 1'b0; imem_ack = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (id_valid) seen = 1;
    end
    n_cmp++;
    if (!seen || id_pc !== 16'h0000) begin
      n_fail++;
      $display("FAIL restart got seen=%0d pc=%h exp 1/0000", seen, id_pc);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_q[$];
    logic [15:0] e;
    int got = 0;
    exp_q.push_back(16'hFFFE); exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0001);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 12 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      if (id_valid2) begin
        e = exp_q.pop_front();
        got++;
        n_cmp++;
        if (id_pc2 !== e || id_inst2 !== 16'(16'hA000 + e)) begin
          n_fail++;
          $display("FAIL wrap got=%h/%h exp=%h/%h", id_pc2, id_inst2, e, 16'(16'hA000 + e));
        end
      end
    end
    n_cmp++;
    if (got != 4) begin
      n_fail++;
      $display("FAIL wrap_count got=%0d exp=4", got);
    end
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      id_ready = 1'($urandom_range(0, 1));
      imem_ack = 1'($urandom_range(0, 1));
      br_taken = ($urandom_range(0, 9) == 0);
      br_target = 16'($urandom_range(0, 16'hFFFF));
      step();
    end
    br_taken = 1'b0; id_ready = 1'b1; imem_ack = 1'b1;
    repeat (4) step();
  endtask

  initial begin
    test_reset();
    test_stall();
    test_branch_full();
    test_branch_ack();
    test_ack_wait_reset();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
